libhdl_quad_decode: RTL and testbench

Quadrature (A/B) incremental-encoder decoder with a position counter. Synchronises and glitch-filters the two asynchronous encoder channels and decodes Gray-code transitions into a one-cycle step strobe plus direction. It keeps a loadable, wrapping position count and flags illegal transitions. It is the producing end of the step/direction interface: o_step/o_up_ndown can drive the i_ce/i_up_ndown inputs of the team's up/down counter, and the internal count already provides that function.

---
 rtl/libhdl_quad_decode.sv | 178 +++++++++++++++++
 tb/tb_libhdl_quad_decode.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/libhdl_quad_decode.sv
`default_nettype none
// ============================================================================
// Module      : libhdl_quad_decode
// Description : Quadrature (A/B) incremental-encoder decoder.
//               Synchronises and glitch-filters both encoder channels, decodes
//               Gray-code transitions into a one-cycle step strobe plus a
//               direction bit, keeps a loadable wrapping position count, and
//               raises a sticky flag on illegal (double-bit) transitions.
//
// Ports       : i_clk       clock, rising edge
//               i_rst       synchronous reset, active-high
//               i_a, i_b    asynchronous encoder channels
//               i_lden      load o_count with i_ldval (priority over steps)
//               i_ldval     load value
//               i_clr_err   clear sticky error flag (a new error wins)
//               o_step      one-cycle pulse per legal transition
//               o_up_ndown  direction of the last step (1 = up)
//               o_count     position count, x4 resolution, wrapping
//               o_err       sticky illegal-transition flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module libhdl_quad_decode #(
  parameter int COUNT_LEN   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_a,
  input  logic                 i_b,
  input  logic                 i_lden,
  input  logic [COUNT_LEN-1:0] i_ldval,
  input  logic                 i_clr_err,
  output logic                 o_step,
  output logic                 o_up_ndown,
  output logic [COUNT_LEN-1:0] o_count,
  output logic                 o_err
);

  localparam int c_filt_w = $clog2(FILT_LEN + 1);
  localparam int c_init_w = $clog2(SYNC_STAGES + 2);
  localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILT_LEN - 1);
  localparam logic [c_init_w-1:0] c_init_len  = c_init_w'(SYNC_STAGES + 1);

  // --------------------------------------------------------------------------
  // Init window: the first SYNC_STAGES+1 edges after reset release let the
  // filtered values track the synchronisers directly so that whatever static
  // position the encoder sits at is absorbed without a step or an error.
  // --------------------------------------------------------------------------
  logic [c_init_w-1:0] r_init_cnt;
  logic                w_init;

  assign w_init = (r_init_cnt != c_init_len);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_init_cnt <= '0;
    end else if (w_init) begin
      r_init_cnt <= r_init_cnt + c_init_w'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel synchroniser and glitch filter. Bit 1 is channel A, bit 0 B.
  // --------------------------------------------------------------------------
  logic [1:0] w_in;
  logic [1:0] w_sync;
  logic [1:0] w_filt;

  assign w_in = {i_a, i_b};

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic [c_filt_w-1:0]    r_fcnt;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sync <= '0;
        r_filt <= 1'b0;
        r_fcnt <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_in[g]};
        if (w_init) begin
          r_filt <= r_sync[SYNC_STAGES-1];
          r_fcnt <= '0;
        end else if (r_sync[SYNC_STAGES-1] == r_filt) begin
          r_fcnt <= '0;
        end else if (r_fcnt == c_filt_last) begin
          // This edge is the FILT_LEN-th consecutive differing sample.
          r_filt <= r_sync[SYNC_STAGES-1];
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + c_filt_w'(1);
        end
      end
    end

    assign w_sync[g] = r_sync[SYNC_STAGES-1];
    assign w_filt[g] = r_filt;
  end : g_chan

  // --------------------------------------------------------------------------
  // Decode. The previous filtered pair is a one-cycle-delayed copy; inside the
  // init window it is loaded with the same value as the filter so both agree
  // when the window closes.
  // --------------------------------------------------------------------------
  logic [1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= 2'b00;
    end else if (w_init) begin
      r_prev <= w_sync;
    end else begin
      r_prev <= w_filt;
    end
  end

  // Map {A,B} onto its position in the up cycle 00,10,11,01 so that the
  // modulo-4 difference directly classifies the transition:
  // 0 = none, 1 = up, 3 = down, 2 = both channels changed (illegal).
  logic [1:0] w_pos_prev;
  logic [1:0] w_pos_cur;
  logic [1:0] w_delta;
  logic       w_step;
  logic       w_up;
  logic       w_bad;

  assign w_pos_prev = {r_prev[0], r_prev[1] ^ r_prev[0]};
  assign w_pos_cur  = {w_filt[0], w_filt[1] ^ w_filt[0]};
  assign w_delta    = w_pos_cur - w_pos_prev;
  assign w_step     = !w_init && w_delta[0];
  assign w_up       = (w_delta == 2'd1);
  assign w_bad      = !w_init && (w_delta == 2'd2);

  // --------------------------------------------------------------------------
  // Registered outputs and position count.
  // --------------------------------------------------------------------------
  logic                 r_step;
  logic                 r_up_ndown;
  logic [COUNT_LEN-1:0] r_count;
  logic                 r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step     <= 1'b0;
      r_up_ndown <= 1'b1;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_step <= w_step;
      if (w_step) begin
        r_up_ndown <= w_up;
      end

      if (i_lden) begin
        r_count <= i_ldval;
      end else if (w_step) begin
        r_count <= w_up ? (r_count + COUNT_LEN'(1)) : (r_count - COUNT_LEN'(1));
      end

      if (w_bad) begin
        r_err <= 1'b1;
      end else if (i_clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_step     = r_step;
  assign o_up_ndown = r_up_ndown;
  assign o_count    = r_count;
  assign o_err      = r_err;

endmodule : libhdl_quad_decode
`default_nettype wire

// File: tb/tb_libhdl_quad_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_libhdl_quad_decode
// Description : Self-checking bench for libhdl_quad_decode. Expected steps
//               (due cycle, direction, resulting count) are queued when an
//               encoder transition is driven and compared when o_step fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_libhdl_quad_decode;

  localparam int c_lat = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b1;
  logic        b = 1'b1;
  logic        lden = 1'b0;
  logic [15:0] ldval = 16'h0000;
  logic        clr_err = 1'b0;
  logic        o_step;
  logic        o_up_ndown;
  logic [15:0] o_count;
  logic        o_err;

  libhdl_quad_decode #(
    .COUNT_LEN  (16),
    .SYNC_STAGES(2),
    .FILT_LEN   (4)
  ) u_dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_a       (a),
    .i_b       (b),
    .i_lden    (lden),
    .i_ldval   (ldval),
    .i_clr_err (clr_err),
    .o_step    (o_step),
    .o_up_ndown(o_up_ndown),
    .o_count   (o_count),
    .o_err     (o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        up;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_count = 16'h0000;
  logic [1:0]  cur_ab = 2'b11;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Position of {A,B} in the up cycle 00 -> 10 -> 11 -> 01.
  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Drive a new A/B pair right after an edge and hold it for 'hold' edges.
  task automatic step_to(input logic na, input logic nb, input int hold);
    int   d;
    exp_t e;
    @(posedge clk); #1;
    d = (pos({na, nb}) - pos(cur_ab) + 4) % 4;
    a = na;
    b = nb;
    if (d == 1) exp_count = exp_count + 16'd1;
    else if (d == 3) exp_count = exp_count - 16'd1;
    if (d == 1 || d == 3) begin
      e.due = cyc + c_lat;
      e.up  = (d == 1);
      e.cnt = exp_count;
      sb.push_back(e);
    end
    cur_ab = {na, nb};
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    @(posedge clk); #1;
    lden  = 1'b1;
    ldval = v;
    @(posedge clk); #1;
    lden = 1'b0;
    exp_count = v;
    check("load_value", o_count, v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: every step must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && !o_step && cyc > sb[0].due) begin
        check("missing_step", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
      if (o_step) begin
        if (sb.size() == 0) begin
          check("unexpected_step", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("step_cycle", cyc, mon_e.due);
          check("step_dir", o_up_ndown, mon_e.up);
          check("step_count", o_count, mon_e.cnt);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  exp_t col_e;

  initial begin
    // Reset with the encoder parked at AB=11.
    idle(5);
    check("rst_step", o_step, 1'b0);
    check("rst_dir", o_up_ndown, 1'b1);
    check("rst_count", o_count, 16'h0000);
    check("rst_err", o_err, 1'b0);
    rst = 1'b0;
    idle(20);
    check("pwr11_count", o_count, 16'h0000);
    check("pwr11_err", o_err, 1'b0);

    // Re-reset with the encoder at AB=00.
    a = 1'b0; b = 1'b0; rst = 1'b1;
    idle(3);
    rst = 1'b0;
    cur_ab = 2'b00;
    exp_count = 16'h0000;
    idle(10);

    // Eight up transitions, then three reverse.
    for (int i = 0; i < 2; i++) begin
      step_to(1'b1, 1'b0, 10);
      step_to(1'b1, 1'b1, 10);
      step_to(1'b0, 1'b1, 10);
      step_to(1'b0, 1'b0, 10);
    end
    idle(5);
    check("up8_dir", o_up_ndown, 1'b1);
    check("up8_count", o_count, 16'd8);
    step_to(1'b0, 1'b1, 10);
    step_to(1'b1, 1'b1, 10);
    step_to(1'b1, 1'b0, 10);
    idle(5);
    check("dn3_dir", o_up_ndown, 1'b0);
    check("dn3_count", o_count, 16'd5);
    step_to(1'b0, 1'b0, 10);   // back to 00, count 4

    // Three-cycle glitch on A is rejected.
    @(posedge clk); #1; a = 1'b1;
    repeat (3) @(posedge clk);
    #1; a = 1'b0;
    idle(15);
    check("glitch_count", o_count, 16'd4);
    // Four-cycle pulse passes: one up then one down.
    step_to(1'b1, 1'b0, 4);
    step_to(1'b0, 1'b0, 15);
    check("pulse_count", o_count, 16'd4);
    check("pulse_dir", o_up_ndown, 1'b0);

    // Wrap in both directions.
    load(16'h0000);
    step_to(1'b0, 1'b1, 10);
    check("wrap_dn", o_count, 16'hFFFF);
    load(16'hFFFF);
    step_to(1'b0, 1'b0, 10);
    check("wrap_up", o_count, 16'h0000);

    // Load on the same edge a step lands: load wins, step still reported.
    @(posedge clk); #1;
    a = 1'b1; b = 1'b0; cur_ab = 2'b10;
    exp_count = 16'h1234;
    col_e.due = cyc + c_lat; col_e.up = 1'b1; col_e.cnt = 16'h1234;
    sb.push_back(col_e);
    repeat (c_lat - 1) @(posedge clk);
    #1; lden = 1'b1; ldval = 16'h1234;
    @(posedge clk); #1; lden = 1'b0;
    idle(5);
    step_to(1'b1, 1'b1, 10);
    check("after_load", o_count, 16'h1235);

    // Illegal transitions and the sticky error flag.
    step_to(1'b0, 1'b1, 10);
    step_to(1'b0, 1'b0, 10);
    check("pre_err", o_err, 1'b0);
    step_to(1'b1, 1'b1, 12);   // both channels at once
    check("err_set", o_err, 1'b1);
    check("err_count", o_count, 16'h1237);
    check("err_dir", o_up_ndown, 1'b1);
    @(posedge clk); #1;
    a = 1'b0; b = 1'b0; cur_ab = 2'b00;
    repeat (c_lat - 1) @(posedge clk);
    #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    check("err_set_wins", o_err, 1'b1);
    idle(5);
    @(posedge clk); #1; clr_err = 1'b1;
    @(posedge clk); #1; clr_err = 1'b0;
    check("err_clear", o_err, 1'b0);

    // Reset in the middle of filtering an edge.
    step_to(1'b0, 1'b1, 10);
    check("pre_rst_dir", o_up_ndown, 1'b0);
    @(posedge clk); #1; a = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_step", o_step, 1'b0);
    check("midrst_dir", o_up_ndown, 1'b1);
    check("midrst_count", o_count, 16'h0000);
    check("midrst_err", o_err, 1'b0);
    idle(2);
    rst = 1'b0;
    cur_ab = 2'b11;
    exp_count = 16'h0000;
    idle(20);
    check("post_rst_count", o_count, 16'h0000);
    check("post_rst_err", o_err, 1'b0);

    idle(10);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_libhdl_quad_decode
`default_nettype wire
